// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its decimal-correction helper.
//   - op encodings for the op input
//   - FSM state enum for the decimal-correction sequencer
//   - BCD correction constants (0x06, 0x60, digit limit 9)
package alu_pkg;

  localparam logic [2:0] OP_SUM = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_EOR = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SR  = 3'b100;
  // 3'b101..3'b111 are reserved: pass aIn through, flags cleared.

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CORRECT = 1'b1
  } alu_state_e;

  localparam logic [7:0] BCD_ADJ_LO    = 8'h06;
  localparam logic [7:0] BCD_ADJ_HI    = 8'h60;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/alu_bcd_adjust.sv
// bcd_adjust: combinational decimal correction of a binary adder result.
// Ports:
//   i_sum    - 8-bit binary sum from the adder
//   i_hc     - binary half-carry (carry out of bit 3)
//   i_carry  - binary carry (carry out of bit 7)
//   i_binv   - 1 = subtract (B was inverted), 0 = add
//   o_result - decimal-corrected byte
//   o_carry  - decimal carry out
// Holds no state; all registers live in alu.
module bcd_adjust
  import alu_pkg::*;
(
  input  logic [7:0] i_sum,
  input  logic       i_hc,
  input  logic       i_carry,
  input  logic       i_binv,
  output logic [7:0] o_result,
  output logic       o_carry
);

  logic       w_lo_fix;
  logic       w_hi_fix;
  logic [7:0] w_lo_adj;

  always_comb begin
    w_lo_fix = 1'b0;
    w_hi_fix = 1'b0;
    w_lo_adj = i_sum;
    o_result = i_sum;
    o_carry  = i_carry;
    if (!i_binv) begin
      // Add: the high-nibble test looks at the byte after the low fix, so a
      // low-digit overflow that ripples into the high digit is caught.
      w_lo_fix = (i_sum[3:0] > BCD_DIGIT_MAX) || i_hc;
      w_lo_adj = w_lo_fix ? (i_sum + BCD_ADJ_LO) : i_sum;
      w_hi_fix = (w_lo_adj[7:4] > BCD_DIGIT_MAX) || i_carry;
      o_result = w_hi_fix ? (w_lo_adj + BCD_ADJ_HI) : w_lo_adj;
      o_carry  = i_carry || w_hi_fix;
    end else begin
      // Subtract: a missing carry out of a digit means that digit borrowed.
      w_lo_fix = !i_hc;
      w_lo_adj = w_lo_fix ? (i_sum - BCD_ADJ_LO) : i_sum;
      w_hi_fix = !i_carry;
      o_result = w_hi_fix ? (w_lo_adj - BCD_ADJ_HI) : w_lo_adj;
      o_carry  = i_carry;
    end
  end

endmodule

// File: rtl/alu.sv
// alu: 8-bit ALU with registered result/flags and a two-state decimal
// correction sequencer.
// Ports:
//   clk, reset        - clock (rising edge), async active-high reset
//   aIn, bIn          - operands A and B
//   cin, binv, dec    - carry in, invert B (subtract), decimal mode
//   op                - operation select (see alu_pkg)
//   start             - request one operation; sampled only while busy=0
//   result            - result hold register
//   acr, avr, hc      - registered carry, overflow, half-carry
//   busy              - decimal correction in progress
//   done              - one-cycle completion pulse
//   o_dbg_state       - current sequencer state (alu_state_e encoding)
// Handshake: an operation is accepted on a rising edge where start=1 and
// busy=0; starts while busy=1 are dropped. done pulses for exactly one cycle
// once result and flags are valid: 1 cycle after accept, 2 for decimal SUM.
module alu
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] aIn,
  input  logic [7:0] bIn,
  input  logic       cin,
  input  logic       binv,
  input  logic       dec,
  input  logic [2:0] op,
  input  logic       start,
  output logic [7:0] result,
  output logic       acr,
  output logic       avr,
  output logic       hc,
  output logic       busy,
  output logic       done,
  output logic       o_dbg_state
);

  alu_state_e r_state;
  logic [7:0] r_result;
  logic       r_acr;
  logic       r_avr;
  logic       r_hc;
  logic       r_done;

  // Binary sum and flags captured at the accept edge of a decimal SUM.
  logic [7:0] r_bin_sum;
  logic       r_bin_c;
  logic       r_bin_v;
  logic       r_bin_hc;
  logic       r_binv;

  logic [7:0] w_bprime;
  logic [8:0] w_sum9;
  logic       w_sum_hc;
  logic       w_sum_v;
  logic [7:0] w_res;
  logic       w_acr;
  logic       w_avr;
  logic       w_hc;
  logic [7:0] w_bcd_res;
  logic       w_bcd_c;

  assign w_bprime = binv ? ~bIn : bIn;
  assign w_sum9   = {1'b0, aIn} + {1'b0, w_bprime} + {8'b0, cin};
  // Carry into bit 4 recovered from the sum bit and the two operand bits.
  assign w_sum_hc = aIn[4] ^ w_bprime[4] ^ w_sum9[4];
  assign w_sum_v  = (aIn[7] == w_bprime[7]) && (w_sum9[7] != aIn[7]);

  always_comb begin
    w_res = aIn;
    w_acr = 1'b0;
    w_avr = 1'b0;
    w_hc  = 1'b0;
    case (op)
      OP_SUM: begin
        w_res = w_sum9[7:0];
        w_acr = w_sum9[8];
        w_avr = w_sum_v;
        w_hc  = w_sum_hc;
      end
      OP_AND: w_res = aIn & bIn;
      OP_EOR: w_res = aIn ^ bIn;
      OP_OR:  w_res = aIn | bIn;
      OP_SR: begin
        w_res = {cin, aIn[7:1]};
        w_acr = aIn[0];
      end
      default: w_res = aIn;
    endcase
  end

  bcd_adjust u_bcd_adjust (
    .i_sum    (r_bin_sum),
    .i_hc     (r_bin_hc),
    .i_carry  (r_bin_c),
    .i_binv   (r_binv),
    .o_result (w_bcd_res),
    .o_carry  (w_bcd_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_result  <= 8'h00;
      r_acr     <= 1'b0;
      r_avr     <= 1'b0;
      r_hc      <= 1'b0;
      r_done    <= 1'b0;
      r_bin_sum <= 8'h00;
      r_bin_c   <= 1'b0;
      r_bin_v   <= 1'b0;
      r_bin_hc  <= 1'b0;
      r_binv    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if ((op == OP_SUM) && dec) begin
              // Operands may change while busy, so capture everything the
              // correction step needs.
              r_bin_sum <= w_sum9[7:0];
              r_bin_c   <= w_sum9[8];
              r_bin_v   <= w_sum_v;
              r_bin_hc  <= w_sum_hc;
              r_binv    <= binv;
              r_state   <= ST_CORRECT;
            end else begin
              r_result <= w_res;
              r_acr    <= w_acr;
              r_avr    <= w_avr;
              r_hc     <= w_hc;
              r_done   <= 1'b1;
            end
          end
        end
        ST_CORRECT: begin
          r_result <= w_bcd_res;
          r_acr    <= w_bcd_c;
          r_avr    <= r_bin_v;
          r_hc     <= r_bin_hc;
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign result      = r_result;
  assign acr         = r_acr;
  assign avr         = r_avr;
  assign hc          = r_hc;
  assign done        = r_done;
  assign busy        = (r_state == ST_CORRECT);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] aIn, bIn;
  logic       cin, binv, dec, start;
  logic [2:0] op;
  logic [7:0] result;
  logic       acr, avr, hc, busy, done, o_dbg_state;

  always #5 clk = ~clk;

  alu dut (
    .clk(clk), .reset(reset), .aIn(aIn), .bIn(bIn), .cin(cin), .binv(binv),
    .dec(dec), .op(op), .start(start), .result(result), .acr(acr),
    .avr(avr), .hc(hc), .busy(busy), .done(done), .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_q[$];   // {result, acr, avr, hc}

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       bv;
    logic       dc;
    logic [2:0] opc;
    logic [7:0] exp_res;
    logic       exp_acr;
    logic       exp_avr;
    logic       exp_hc;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       acr;
    logic       avr;
    logic       hc;
  } res_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // done and busy must never overlap.
  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if (busy && done) begin
        n_fail++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b expected not both 1", busy, done);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic res_t model(input logic [7:0] a8, input logic [7:0] b8,
                                 input logic ci, input logic bv, input logic dc,
                                 input logic [2:0] opc);
    res_t r;
    int a, b, bp, s, sa, sb, sv, c_i;
    bit carry, half;
    r  = '{res: 8'h00, acr: 1'b0, avr: 1'b0, hc: 1'b0};
    a  = int'(a8);
    b  = int'(b8);
    c_i = ci ? 1 : 0;
    case (opc)
      3'd0: begin
        bp    = bv ? 255 - b : b;
        s     = a + bp + c_i;
        carry = (s > 255);
        half  = ((a % 16) + (bp % 16) + c_i) > 15;
        sa    = (a > 127) ? a - 256 : a;
        sb    = (bp > 127) ? bp - 256 : bp;
        sv    = sa + sb + c_i;
        r.avr = (sv > 127) || (sv < -128);
        r.hc  = half;
        r.acr = carry;
        s     = s % 256;
        if (dc) begin
          if (!bv) begin
            if ((s % 16) > 9 || half) s = (s + 6) % 256;
            if ((s / 16) > 9 || carry) begin
              s     = (s + 96) % 256;
              r.acr = 1'b1;
            end
          end else begin
            if (!half)  s = (s + 256 - 6) % 256;
            if (!carry) s = (s + 256 - 96) % 256;
          end
        end
        r.res = s[7:0];
      end
      3'd1: r.res = a8 & b8;
      3'd2: r.res = a8 ^ b8;
      3'd3: r.res = a8 | b8;
      3'd4: begin
        s     = c_i * 128 + a / 2;
        r.res = s[7:0];
        r.acr = (a % 2) == 1;
      end
      default: r.res = a8;
    endcase
    return r;
  endfunction

  // ---------------- driver ----------------
  // Applies one operation and checks latency, busy, result, flags and the
  // single-cycle done pulse against the head of exp_q.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    int exp_lat;
    logic [10:0] e;
    aIn = v.a; bIn = v.b; cin = v.ci; binv = v.bv; dec = v.dc; op = v.opc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_lat = ((v.opc == OP_SUM) && v.dc) ? 2 : 1;
    check({tag, "_busy"}, busy, (exp_lat == 2) ? 1 : 0);
    lat = 1;
    while (!done && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_queue: expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, result, e[10:3]);
      check({tag, "_flags"}, {acr, avr, hc}, e[2:0]);
    end
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    res_t m;
    logic [7:0] hold_val;

    vecs[0]  = '{8'h45, 8'h37, 0, 0, 0, OP_SUM, 8'h7C, 0, 0, 0};
    vecs[1]  = '{8'h50, 8'h50, 0, 0, 0, OP_SUM, 8'hA0, 0, 1, 0};
    vecs[2]  = '{8'h99, 8'h01, 0, 0, 1, OP_SUM, 8'h00, 1, 0, 0};
    vecs[3]  = '{8'h50, 8'h01, 1, 1, 1, OP_SUM, 8'h49, 1, 0, 0};
    vecs[4]  = '{8'h81, 8'h00, 1, 0, 0, OP_SR,  8'hC0, 1, 0, 0};
    vecs[5]  = '{8'hF0, 8'h3C, 0, 0, 0, OP_AND, 8'h30, 0, 0, 0};
    vecs[6]  = '{8'hF0, 8'h3C, 1, 1, 0, OP_EOR, 8'hCC, 0, 0, 0};
    vecs[7]  = '{8'hA5, 8'h0F, 0, 0, 0, OP_OR,  8'hAF, 0, 0, 0};
    vecs[8]  = '{8'h5A, 8'hFF, 1, 1, 1, 3'b101, 8'h5A, 0, 0, 0};
    vecs[9]  = '{8'h10, 8'h20, 1, 1, 0, OP_SUM, 8'hF0, 0, 0, 1};
    vecs[10] = '{8'hFF, 8'h01, 0, 0, 0, OP_SUM, 8'h00, 1, 0, 1};
    vecs[11] = '{8'h15, 8'h27, 0, 0, 1, OP_SUM, 8'h42, 0, 0, 0};

    // Reset state
    reset = 1'b1; start = 1'b0; aIn = 8'h00; bIn = 8'h00;
    cin = 1'b0; binv = 1'b0; dec = 1'b0; op = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 8'h00);
    check("reset_flags", {acr, avr, hc}, 3'b000);
    check("reset_busy_done", {busy, done}, 2'b00);
    check("reset_state", o_dbg_state, ST_IDLE);
    reset = 1'b0;   // first op below is accepted on the very next edge

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({vecs[i].exp_res, vecs[i].exp_acr, vecs[i].exp_avr, vecs[i].exp_hc});
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Hold between operations while inputs wander
    hold_val = result;
    check("hold_nonzero_setup", hold_val, 8'h42);
    for (int i = 0; i < 3; i++) begin
      aIn = 8'($urandom); bIn = 8'($urandom); op = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      check("hold_result", result, 8'h42);
    end

    // Start during busy is ignored
    aIn = 8'h99; bIn = 8'h01; cin = 0; binv = 0; dec = 1; op = OP_SUM; start = 1;
    @(posedge clk); #1;
    check("ign_busy", busy, 1);
    check("ign_state", o_dbg_state, ST_CORRECT);
    aIn = 8'hFF; bIn = 8'hFF; dec = 0; op = OP_AND; start = 1;
    @(posedge clk); #1;
    start = 0;
    check("ign_done", done, 1);
    check("ign_result", result, 8'h00);
    check("ign_acr", acr, 1);
    @(posedge clk); #1;
    check("ign_no_second_done", done, 0);
    check("ign_result_hold", result, 8'h00);

    // Reset during CORRECT aborts the operation
    v = '{8'hFF, 8'h0F, 0, 0, 0, OP_AND, 8'h0F, 0, 0, 0};
    exp_q.push_back({8'h0F, 3'b000});
    run_op(v, "pre_abort");
    aIn = 8'h15; bIn = 8'h27; dec = 1; op = OP_SUM; start = 1;
    @(posedge clk); #1;
    start = 0;
    check("abort_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_async_result", result, 8'h00);
    check("abort_async_busy_done", {busy, done}, 2'b00);
    @(posedge clk); #1;
    check("abort_no_done", done, 0);
    check("abort_state", o_dbg_state, ST_IDLE);
    reset = 1'b0;
    exp_q.push_back({8'h42, 3'b000});
    run_op(vecs[11], "post_abort");

    // Randomised operations against the reference model
    for (int i = 0; i < 200; i++) begin
      v.a   = 8'($urandom);
      v.b   = 8'($urandom);
      v.ci  = 1'($urandom_range(0, 1));
      v.bv  = 1'($urandom_range(0, 1));
      v.dc  = 1'($urandom_range(0, 1));
      v.opc = (i % 2 == 0) ? OP_SUM : 3'($urandom_range(0, 7));
      m = model(v.a, v.b, v.ci, v.bv, v.dc, v.opc);
      v.exp_res = m.res; v.exp_acr = m.acr; v.exp_avr = m.avr; v.exp_hc = m.hc;
      exp_q.push_back({m.res, m.acr, m.avr, m.hc});
      run_op(v, $sformatf("rnd%0d_op%0d_a%02h_b%02h", i, v.opc, v.a, v.b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port aIn, input, 8 bits: operand A, taken from the pre-ALU A latch output.
REQ-004 SHALL have port bIn, input, 8 bits: operand B, taken from the pre-ALU B latch output.
REQ-005 SHALL have port cin, input, 1 bit: carry in.
REQ-006 SHALL have port binv, input, 1 bit: invert B before SUM; used for subtract.
REQ-007 SHALL have port dec, input, 1 bit: decimal (BCD) mode for SUM.
REQ-008 SHALL have port op, input, 3 bits with encodings:
- 000 SUM
- 001 AND
- 010 EOR
- 011 OR
- 100 SR
- 101-111 reserved
REQ-009 SHALL have port start, input, 1 bit: request one operation.
REQ-010 SHALL have port result, output, 8 bits: adder hold register.
REQ-011 SHALL have ports acr, avr and hc, outputs, 1 bit each: registered carry, overflow and half-carry.
REQ-012 SHALL have ports busy and done, outputs, 1 bit each: decimal correction in progress, and one-cycle completion pulse.

Function
REQ-013 SHALL sample start only when busy=0; start while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-014 On an accepted start with op other than SUM+dec, SHALL update result and flags at that same edge, with done=1 for exactly the following cycle (latency 1).
REQ-015 SUM SHALL compute the 9-bit aIn + B' + cin:
- B' = ~bIn when binv=1, else bIn.
- acr = bit 8; hc = carry out of bit 3.
- avr = (aIn[7]==B'[7]) && (sum[7]!=aIn[7]).
REQ-016 AND, EOR and OR SHALL compute bitwise aIn op bIn (binv ignored), with acr=0, avr=0 and hc=0.
REQ-017 SR SHALL compute result = {cin, aIn[7:1]}, with acr=aIn[0], avr=0 and hc=0.
REQ-018 Reserved op codes SHALL give result=aIn with all flags 0, and still produce done.
REQ-019 SUM with dec=1 SHALL use a two-state FSM:
- IDLE -> CORRECT on the accept edge: binary sum, hc, acr and avr latched internally; busy=1.
- CORRECT -> IDLE on the next edge: corrected result and flags written; done=1 the following cycle.
REQ-020 Decimal add (binv=0): add 0x06 if low nibble >9 or hc=1; then add 0x60 if high nibble >9 or binary carry=1, in which case acr=1; otherwise acr keeps the binary carry.
REQ-021 Decimal subtract (binv=1): subtract 0x06 if hc=0; subtract 0x60 if binary carry=0; acr is the binary carry.
REQ-022 In decimal mode, avr SHALL be the binary-sum overflow; hc is the binary half-carry.
REQ-023 All 8-bit arithmetic SHALL wrap modulo 256.
REQ-024 result and flags SHALL hold their value between operations.
REQ-025 done and busy SHALL never both be 1 in the same cycle.

Reset
REQ-026 reset=1 SHALL asynchronously force:
- result=0x00
- acr=avr=hc=0
- busy=0, done=0
- FSM=IDLE
REQ-027 reset asserted during CORRECT SHALL abort the operation, and no done SHALL follow.
REQ-028 The first start SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-029 Shared package alu_pkg SHALL hold:
- op encodings
- FSM state enum
- BCD constants 0x06, 0x60 and 9
REQ-030 BCD correction SHALL be a combinational sub-module named bcd_adjust: binary sum, hc, carry, binv in; corrected byte and carry out.
REQ-031 Flag and result registers SHALL live only in alu; the sub-module SHALL hold no state.

Verification
REQ-032 SUM, dec=0: aIn=0x45, bIn=0x37, cin=0 -> result=0x7C, acr=0, avr=0, hc=0; done 1 cycle after start.
REQ-033 SUM, dec=0: aIn=0x50, bIn=0x50, cin=0 -> result=0xA0, avr=1, acr=0.
REQ-034 SUM, dec=1: aIn=0x99, bIn=0x01, cin=0 -> busy for 1 cycle, then result=0x00, acr=1; done 2 cycles after start. A start issued during busy is ignored.
REQ-035 SUM, dec=1, binv=1: aIn=0x50, bIn=0x01, cin=1 -> result=0x49, acr=1.
REQ-036 SR: aIn=0x81, cin=1 -> result=0xC0, acr=1; then AND: 0xF0 & 0x3C -> result=0x30, flags 0.
REQ-037 Reset in CORRECT after a decimal start -> result=0x00, busy=0, no done pulse; the next start completes normally.
